// File: rtl/fifo_sum_sched.sv
// Sequencer for the three-row vertical-sum datapath: syncs UART pixels, fills two
// line-buffer FIFOs, then sums each new pixel with the two buffered rows and rotates rows.
module fifo_sum_sched #(
    parameter int ROW = 6,
    parameter int COL = 5
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       valid_flag,
    output logic [7:0] fifo1_din,
    output logic       fifo1_wr_en,
    output logic       fifo1_rd_en,
    input  logic [7:0] fifo1_q,
    input  logic       fifo1_empty,
    output logic [7:0] fifo2_din,
    output logic       fifo2_wr_en,
    output logic       fifo2_rd_en,
    input  logic [7:0] fifo2_q,
    input  logic       fifo2_empty,
    output logic       fifo_clr,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       sat,
    output logic       frame_done,
    output logic       err
);
    localparam int CW = $clog2(COL + 1);
    localparam int RW = $clog2(ROW + 1);

    typedef enum logic [2:0] {
        ST_FILL1, ST_FILL2, ST_RD, ST_RDEN, ST_WAIT, ST_WR, ST_CLR
    } state_t;

    state_t        state, state_nxt;
    logic          v1, v2, pix_stb, acc_d;
    logic [7:0]    pix_reg, q1_r, q2_r;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          err_r;
    logic          in_fill, last_col, last_row;
    logic [9:0]    sum;

    assign in_fill  = (state == ST_FILL1) || (state == ST_FILL2);
    assign last_col = (col_cnt == CW'(COL - 1));
    assign last_row = (row_cnt == RW'(ROW - 1));
    assign sum      = 10'(q1_r) + 10'(q2_r) + 10'(pix_reg);
    assign err      = err_r;

    // acc_d marks the write cycle of a pixel accepted while filling; stray strobes elsewhere are dropped
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            pix_stb <= 1'b0;
            acc_d   <= 1'b0;
            pix_reg <= '0;
        end else begin
            v1      <= valid_flag;
            v2      <= v1;
            pix_stb <= v1 & ~v2;
            acc_d   <= pix_stb & in_fill;
            if (v1 & ~v2) pix_reg <= rx_data;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FILL1;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL1: if (acc_d && last_col) state_nxt = ST_FILL2;
            ST_FILL2: if (acc_d && last_col) state_nxt = ST_RD;
            ST_RD:    if (pix_stb) state_nxt = ST_RDEN;
            ST_RDEN:  state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_WR;
            ST_WR:    state_nxt = (last_row && last_col) ? ST_CLR : ST_RD;
            ST_CLR:   state_nxt = ST_FILL1;
            default:  state_nxt = ST_FILL1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
            q1_r    <= '0;
            q2_r    <= '0;
            err_r   <= 1'b0;
        end else begin
            if (state == ST_CLR) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else if ((in_fill && acc_d) || state == ST_WR) begin
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
            if (state == ST_WAIT) begin
                q1_r <= fifo1_q;
                q2_r <= fifo2_q;
            end
            if (state == ST_RDEN && (fifo1_empty || fifo2_empty)) err_r <= 1'b1;
        end
    end

    // WR rotates rows: FIFO2's old row moves into FIFO1, the new pixel goes to FIFO2
    always_comb begin
        fifo1_din   = pix_reg;
        fifo1_wr_en = 1'b0;
        fifo1_rd_en = 1'b0;
        fifo2_din   = pix_reg;
        fifo2_wr_en = 1'b0;
        fifo2_rd_en = 1'b0;
        fifo_clr    = 1'b0;
        tx_data     = '0;
        tx_en       = 1'b0;
        sat         = 1'b0;
        frame_done  = 1'b0;
        case (state)
            ST_FILL1: fifo1_wr_en = acc_d;
            ST_FILL2: fifo2_wr_en = acc_d;
            ST_RDEN: begin
                fifo1_rd_en = 1'b1;
                fifo2_rd_en = 1'b1;
            end
            ST_WR: begin
                fifo1_din   = q2_r;
                fifo1_wr_en = 1'b1;
                fifo2_wr_en = 1'b1;
                tx_en       = 1'b1;
                sat         = (sum > 10'd255);
                tx_data     = (sum > 10'd255) ? 8'd255 : sum[7:0];
            end
            ST_CLR: begin
                fifo_clr   = 1'b1;
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fifo_sum_sched.sv
// Directed bench for fifo_sum_sched with behavioural line-buffer FIFOs and an output monitor.
module tb_fifo_sum_sched;
    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       valid_flag;
    logic [7:0] fifo1_din, fifo2_din, fifo1_q, fifo2_q, tx_data;
    logic       fifo1_wr_en, fifo1_rd_en, fifo2_wr_en, fifo2_rd_en;
    logic       fifo1_empty, fifo2_empty, fifo_clr, tx_en, sat, frame_done, err;
    logic       force_e1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc, wr1, wr2, rd1, rd2, clr_cnt, done_cnt, done_cyc, ovl, stray;
    logic [7:0] txq[$];
    logic       satq[$];
    int         txcyc[$];
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    int         n1, n2;

    fifo_sum_sched #(.ROW(6), .COL(5)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .rx_data(rx_data), .valid_flag(valid_flag),
        .fifo1_din(fifo1_din), .fifo1_wr_en(fifo1_wr_en), .fifo1_rd_en(fifo1_rd_en),
        .fifo1_q(fifo1_q), .fifo1_empty(fifo1_empty),
        .fifo2_din(fifo2_din), .fifo2_wr_en(fifo2_wr_en), .fifo2_rd_en(fifo2_rd_en),
        .fifo2_q(fifo2_q), .fifo2_empty(fifo2_empty),
        .fifo_clr(fifo_clr), .tx_data(tx_data), .tx_en(tx_en), .sat(sat),
        .frame_done(frame_done), .err(err)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            f1.delete(); f2.delete();
            fifo1_q <= 8'd0; fifo2_q <= 8'd0;
            n1 <= 0; n2 <= 0;
        end else if (fifo_clr) begin
            f1.delete(); f2.delete();
            n1 <= 0; n2 <= 0;
        end else begin
            if (fifo1_rd_en && f1.size() > 0) fifo1_q <= f1.pop_front();
            if (fifo2_rd_en && f2.size() > 0) fifo2_q <= f2.pop_front();
            if (fifo1_wr_en) f1.push_back(fifo1_din);
            if (fifo2_wr_en) f2.push_back(fifo2_din);
            n1 <= f1.size();
            n2 <= f2.size();
        end
    end
    assign fifo1_empty = (n1 == 0) || force_e1;
    assign fifo2_empty = (n2 == 0);

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            if (tx_en) stray++;
        end else begin
            if (tx_en) begin
                txq.push_back(tx_data); satq.push_back(sat); txcyc.push_back(cyc);
            end
            if (fifo1_wr_en) wr1++;
            if (fifo2_wr_en) wr2++;
            if (fifo1_rd_en) rd1++;
            if (fifo2_rd_en) rd2++;
            if ((fifo1_wr_en && fifo1_rd_en) || (fifo2_wr_en && fifo2_rd_en)) ovl++;
            if (fifo_clr) clr_cnt++;
            if (frame_done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: run did not finish, got cycle %0d required < 40000", cyc);
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_mon();
        txq.delete(); satq.delete(); txcyc.delete();
        wr1 = 0; wr2 = 0; rd1 = 0; rd2 = 0; clr_cnt = 0; done_cnt = 0;
        done_cyc = 0; ovl = 0; stray = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid_flag = 1'b0; rx_data = 8'd0; force_e1 = 1'b0;
        step(3);
        clear_mon();
        rst_n = 1'b1;
        step(2);
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'(10 * (k / 5) + (k % 5));
    endfunction

    task automatic send_pix(input logic [7:0] b);
        rise_cyc = cyc;
        rx_data = b; valid_flag = 1'b1;
        step(3);
        valid_flag = 1'b0;
        step(9);
    endtask

    // mode < 0: pixel(r,c) = 10r+c, otherwise every pixel = mode
    task automatic send_frame(input int mode, input int first, input int last);
        for (int k = first; k < last; k++) send_pix(mode < 0 ? pat(k) : 8'(mode));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_flag = 1'b0; rx_data = 8'd0; force_e1 = 1'b0;
        clear_mon();
        step(3);
        checks++;
        if ({tx_en, sat, frame_done, fifo_clr, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b required 00000", {tx_en, sat, frame_done, fifo_clr, err});
        end
        checks++;
        if ({fifo1_wr_en, fifo1_rd_en, fifo2_wr_en, fifo2_rd_en} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes got %b required 0000", {fifo1_wr_en, fifo1_rd_en, fifo2_wr_en, fifo2_rd_en});
        end
        checks++;
        if ({tx_data, fifo1_din, fifo2_din} !== 24'd0) begin
            errors++; $display("FAIL reset_data got %h required 000000", {tx_data, fifo1_din, fifo2_din});
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_frame();
        do_reset();
        send_frame(-1, 0, 10);
        checks++;
        if (wr1 !== 5 || wr2 !== 5) begin
            errors++; $display("FAIL fill_writes got %0d/%0d required 5/5", wr1, wr2);
        end
        checks++;
        if (rd1 !== 0 || rd2 !== 0 || txq.size() !== 0) begin
            errors++; $display("FAIL fill_no_reads got rd %0d/%0d tx %0d required 0/0 0", rd1, rd2, txq.size());
        end
        send_pix(pat(10));
        checks++;
        if (rd1 !== 1 || rd2 !== 1) begin
            errors++; $display("FAIL first_read got %0d/%0d required 1/1", rd1, rd2);
        end
        checks++;
        if (txcyc.size() !== 1 || txcyc[0] - rise_cyc !== 5) begin
            errors++; $display("FAIL latency got %0d required 5", txcyc.size() > 0 ? txcyc[0] - rise_cyc : -1);
        end
        send_frame(-1, 11, 30);
        step(3);
        checks++;
        if (txq.size() !== 20) begin
            errors++; $display("FAIL frame_count got %0d required 20", txq.size());
        end
        for (int i = 0; i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== 8'(30 + 30 * (i / 5) + 3 * (i % 5)) || satq[i] !== 1'b0) begin
                errors++; $display("FAIL frame_sum[%0d] got %0d sat %b required %0d sat 0",
                                   i, txq[i], satq[i], 30 + 30 * (i / 5) + 3 * (i % 5));
            end
        end
        checks++;
        if (err !== 1'b0 || ovl !== 0) begin
            errors++; $display("FAIL frame_err got err %b overlaps %0d required 0 0", err, ovl);
        end
        checks++;
        if (done_cnt !== 1 || clr_cnt !== 1) begin
            errors++; $display("FAIL frame_done_cnt got %0d/%0d required 1/1", done_cnt, clr_cnt);
        end
        checks++;
        if (txcyc.size() != 20 || done_cyc !== txcyc[19] + 1) begin
            errors++; $display("FAIL frame_done_timing got %0d required %0d", done_cyc, txcyc.size() == 20 ? txcyc[19] + 1 : -1);
        end
        txq.delete(); satq.delete(); txcyc.delete();
        send_frame(-1, 0, 30);
        step(3);
        checks++;
        if (txq.size() !== 20 || done_cnt !== 2) begin
            errors++; $display("FAIL frame2_count got %0d done %0d required 20 done 2", txq.size(), done_cnt);
        end
        for (int i = 0; i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== 8'(30 + 30 * (i / 5) + 3 * (i % 5))) begin
                errors++; $display("FAIL frame2_sum[%0d] got %0d required %0d", i, txq[i], 30 + 30 * (i / 5) + 3 * (i % 5));
            end
        end
    endtask

    task automatic test_const(input int px, input logic exp_sat);
        do_reset();
        send_frame(px, 0, 30);
        step(3);
        checks++;
        if (txq.size() !== 20) begin
            errors++; $display("FAIL const%0d_count got %0d required 20", px, txq.size());
        end
        for (int i = 0; i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== 8'd255 || satq[i] !== exp_sat) begin
                errors++; $display("FAIL const%0d[%0d] got %0d sat %b required 255 sat %b", px, i, txq[i], satq[i], exp_sat);
            end
        end
    endtask

    task automatic test_err();
        do_reset();
        send_frame(-1, 0, 10);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_before got %b required 0", err);
        end
        rise_cyc = cyc;
        rx_data = pat(10); valid_flag = 1'b1; force_e1 = 1'b1;
        step(3);
        valid_flag = 1'b0;
        step(1);
        force_e1 = 1'b0;
        step(8);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_set got %b required 1", err);
        end
        checks++;
        if (txq.size() !== 1 || txq[0] !== 8'd30) begin
            errors++; $display("FAIL err_sum got n=%0d v=%0d required n=1 v=30", txq.size(), txq.size() > 0 ? txq[0] : 8'd0);
        end
        send_frame(-1, 11, 30);
        step(3);
        checks++;
        if (err !== 1'b1 || txq.size() !== 20) begin
            errors++; $display("FAIL err_sticky got err %b n=%0d required 1 n=20", err, txq.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(-1, 0, 17);
        rst_n = 1'b0;
        step(1);
        checks++;
        if ({tx_en, fifo_clr, err, fifo1_wr_en, fifo2_wr_en, fifo1_rd_en, fifo2_rd_en} !== 7'b0) begin
            errors++; $display("FAIL midrst_outputs got %b required 0000000",
                               {tx_en, fifo_clr, err, fifo1_wr_en, fifo2_wr_en, fifo1_rd_en, fifo2_rd_en});
        end
        step(2);
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL midrst_stray got %0d required 0", stray);
        end
        clear_mon();
        rst_n = 1'b1;
        step(2);
        send_frame(-1, 0, 30);
        step(3);
        checks++;
        if (txq.size() !== 20 || done_cnt !== 1) begin
            errors++; $display("FAIL midrst_count got %0d done %0d required 20 done 1", txq.size(), done_cnt);
        end
        for (int i = 0; i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== 8'(30 + 30 * (i / 5) + 3 * (i % 5))) begin
                errors++; $display("FAIL midrst_sum[%0d] got %0d required %0d", i, txq[i], 30 + 30 * (i / 5) + 3 * (i % 5));
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        rx_data = 8'd7; valid_flag = 1'b1;
        step(100);
        valid_flag = 1'b0;
        step(5);
        checks++;
        if (wr1 !== 1 || wr2 !== 0) begin
            errors++; $display("FAIL hold_pixels got %0d/%0d required 1/0", wr1, wr2);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_const(200, 1'b1);
        test_const(85, 1'b0);
        test_err();
        test_reset_mid();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
